// File: rtl/fetch_queue_if.sv
// Shared types and handshake bundles for the instruction prefetch unit.
//
// fetch_queue_pkg
//   bus_transfer_t : bus transfer type (IDLE, BUSY, NONSEQ, SEQ).
//   bus_response_t : bus response (OKAY, ERROR).
//
// bus_master : fetcher-to-memory bus.
//   address   [31:0] read address, held for the whole transfer
//   write            always 0 from the fetcher
//   trans            transfer type
//   available        slave can take a new transfer
//   ready            slave completes the current transfer / accepts a new one
//   response         OKAY or ERROR, valid when ready is high
//   read_data [31:0] read word, valid when ready is high
//   modports: out (fetcher side), slave (memory side)
//
// skid_buffer_port : valid/ready stream of instruction words.
//   valid, data [31:0] from producer; ready from consumer
//   modports: downstream (producer side), upstream (consumer side)

package fetch_queue_pkg;
    typedef enum logic [1:0] {
        BUS_TRANSFER_IDLE   = 2'b00,
        BUS_TRANSFER_BUSY   = 2'b01,
        BUS_TRANSFER_NONSEQ = 2'b10,
        BUS_TRANSFER_SEQ    = 2'b11
    } bus_transfer_t;

    typedef enum logic {
        BUS_RESPONSE_OKAY  = 1'b0,
        BUS_RESPONSE_ERROR = 1'b1
    } bus_response_t;
endpackage

interface bus_master;
    logic [31:0]                   address;
    logic                          write;
    fetch_queue_pkg::bus_transfer_t trans;
    logic                          available;
    logic                          ready;
    fetch_queue_pkg::bus_response_t response;
    logic [31:0]                   read_data;

    modport out (
        output address, write, trans,
        input  available, ready, response, read_data
    );

    modport slave (
        input  address, write, trans,
        output available, ready, response, read_data
    );
endinterface

interface skid_buffer_port;
    logic        valid;
    logic [31:0] data;
    logic        ready;

    modport downstream (
        output valid, data,
        input  ready
    );

    modport upstream (
        input  valid, data,
        output ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch unit. Keeps a sequential fetch pointer, reads words
// over the bus one transfer at a time and queues them in a DEPTH-entry FIFO
// feeding the decoder. A redirect flushes the FIFO, drops any response still
// in flight and restarts fetch at the new address. A bus error is queued as a
// tagged entry and fetch halts until the next redirect.
//
// Parameters
//   DEPTH    : FIFO entries, power of two, >= 2
//   RESET_PC : fetch pointer after reset, word aligned
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-low reset
//   redirect     one-cycle flush/restart pulse
//   redirect_pc  restart address, bits [1:0] ignored
//   bus          bus_master.out, read-only fetch port
//   decoder      skid_buffer_port.downstream, instruction word stream
//   decoder_pc   address of the FIFO head word
//   fetch_error  FIFO head is a bus-error entry
//
// Build option
//   FETCH_QUEUE_BURST_EN : chain back-to-back transfers with SEQ while the
//   FIFO has room, giving one word per cycle; NONSEQ restarts at every 1 KB
//   boundary. Without it every transfer is NONSEQ followed by an IDLE cycle.

module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    bus_master.out                     bus,
    skid_buffer_port.downstream        decoder,
    output logic [31:0]                decoder_pc,
    output logic                       fetch_error
);
    import fetch_queue_pkg::*;

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAITING,
        ST_DISCARD,
        ST_HALTED
    } state_t;

    state_t             state_q;
    logic [31:0]        fp_q;
    logic [31:0]        fp_seq_d;
    logic [31:0]        address_q;
    bus_transfer_t      trans_q;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;

    logic [31:0]        pc_mem_q   [DEPTH];
    logic [31:0]        data_mem_q [DEPTH];
    logic               err_mem_q  [DEPTH];

    logic               pop;
    logic               push;
    logic               push_err;
    logic               unused_pc_low;

    // The low address bits of a redirect target are forced to zero.
    assign unused_pc_low = ^redirect_pc[1:0];

    assign fp_seq_d = fp_q + 32'd4;

    // A completed transfer is queued unless a redirect makes it stale; the
    // pop is likewise cancelled by a redirect through count_d.
    always_comb begin
        pop      = decoder.valid && decoder.ready;
        push     = 1'b0;
        push_err = 1'b0;
        if (!redirect && state_q == ST_WAITING && bus.ready) begin
            push     = 1'b1;
            push_err = (bus.response == BUS_RESPONSE_ERROR);
        end
    end

    always_comb begin
        count_d = count_q;
        if (redirect) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Fetch FSM, fetch pointer, registered bus outputs and FIFO bookkeeping.
    // Only one transfer is ever outstanding, and issue requires a free slot,
    // so the response of an issued transfer always has room to land.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            fp_q      <= RESET_PC;
            address_q <= '0;
            trans_q   <= BUS_TRANSFER_IDLE;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
        end else begin
            count_q <= count_d;
            if (pop && !redirect) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end

            if (redirect) begin
                // A transfer still waiting on the bus must be allowed to
                // finish before a new one starts, hence DISCARD.
                fp_q     <= {redirect_pc[31:2], 2'b00};
                trans_q  <= BUS_TRANSFER_IDLE;
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                if ((state_q == ST_WAITING || state_q == ST_DISCARD) && !bus.ready) begin
                    state_q <= ST_DISCARD;
                end else begin
                    state_q <= ST_IDLE;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.available && bus.ready && count_q < DEPTH_C) begin
                            address_q <= fp_q;
                            trans_q   <= BUS_TRANSFER_NONSEQ;
                            state_q   <= ST_WAITING;
                        end else begin
                            trans_q <= BUS_TRANSFER_IDLE;
                        end
                    end
                    ST_WAITING: begin
                        if (bus.ready) begin
                            if (bus.response == BUS_RESPONSE_ERROR) begin
                                trans_q <= BUS_TRANSFER_IDLE;
                                state_q <= ST_HALTED;
                            end else begin
                                fp_q <= fp_seq_d;
`ifdef FETCH_QUEUE_BURST_EN
                                // Keep streaming while the FIFO still has room
                                // after this push; a 1 KB boundary restarts
                                // the burst with NONSEQ.
                                if (count_d < DEPTH_C) begin
                                    address_q <= fp_seq_d;
                                    trans_q   <= (fp_seq_d[9:0] == 10'd0) ?
                                                 BUS_TRANSFER_NONSEQ : BUS_TRANSFER_SEQ;
                                end else begin
                                    trans_q <= BUS_TRANSFER_IDLE;
                                    state_q <= ST_IDLE;
                                end
`else
                                trans_q <= BUS_TRANSFER_IDLE;
                                state_q <= ST_IDLE;
`endif
                            end
                        end
                    end
                    ST_DISCARD: begin
                        trans_q <= BUS_TRANSFER_IDLE;
                        if (bus.ready) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_HALTED: begin
                        trans_q <= BUS_TRANSFER_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // FIFO storage. Error entries carry a zero data word. The storage is
    // cleared at reset so the head fields read zero out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
                err_mem_q[i]  <= 1'b0;
            end
        end else if (push) begin
            pc_mem_q[wr_ptr_q]   <= fp_q;
            data_mem_q[wr_ptr_q] <= push_err ? 32'h0 : bus.read_data;
            err_mem_q[wr_ptr_q]  <= push_err;
        end
    end

    assign bus.address   = address_q;
    assign bus.write     = 1'b0;
    assign bus.trans     = trans_q;

    assign decoder.valid = (count_q != '0);
    assign decoder.data  = data_mem_q[rd_ptr_q];
    assign decoder_pc    = pc_mem_q[rd_ptr_q];
    assign fetch_error   = err_mem_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed testbench for fetch_queue with a small wait-state memory model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clock;
    logic        reset;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [31:0] decoderPc;
    logic        fetchError;
    logic        decReady;
    logic        busAvailable;
    int          waitStates;
    int          waitCnt;
    logic        discardPending;
    logic        outstanding;
    logic [31:0] errAddr;

    int checks   = 0;
    int failures = 0;

    bus_master       busIf ();
    skid_buffer_port decIf ();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirectPc),
        .bus         (busIf),
        .decoder     (decIf),
        .decoder_pc  (decoderPc),
        .fetch_error (fetchError)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: a transfer is outstanding while trans is not IDLE, or
    // after a redirect abandoned a transfer the slave had not yet finished.
    assign outstanding     = (busIf.trans != BUS_TRANSFER_IDLE) || discardPending;
    assign busIf.ready     = !outstanding || (waitCnt >= waitStates);
    assign busIf.available = busAvailable;
    assign busIf.read_data = memWord(busIf.address);
    assign busIf.response  = (outstanding && busIf.address == errAddr) ?
                             BUS_RESPONSE_ERROR : BUS_RESPONSE_OKAY;
    assign decIf.ready     = decReady;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            waitCnt        <= 0;
            discardPending <= 1'b0;
        end else begin
            if (outstanding && !busIf.ready) waitCnt <= waitCnt + 1;
            else waitCnt <= 0;
            if (redirect && busIf.trans != BUS_TRANSFER_IDLE && !busIf.ready)
                discardPending <= 1'b1;
            else if (discardPending && busIf.ready)
                discardPending <= 1'b0;
        end
    end

    task automatic applyRedirect(input logic [31:0] target);
        redirect   = 1'b1;
        redirectPc = target;
        @(negedge clock);
        redirect   = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        checks++; if (busIf.trans !== BUS_TRANSFER_IDLE) begin failures++; $display("[TB] FAIL reset_trans: got %0d want 0", busIf.trans); end
        checks++; if (busIf.address !== 32'h0) begin failures++; $display("[TB] FAIL reset_address: got %h want 0", busIf.address); end
        checks++; if (busIf.write !== 1'b0) begin failures++; $display("[TB] FAIL reset_write: got %b want 0", busIf.write); end
        checks++; if ({decIf.valid, decIf.data, decoderPc, fetchError} !== 66'h0) begin failures++; $display("[TB] FAIL reset_decoder: got v=%b d=%h pc=%h e=%b want all 0", decIf.valid, decIf.data, decoderPc, fetchError); end
    endtask

    task automatic test_sequential();
        int n;
        logic [31:0] expPc;
        reset = 1'b1;
        @(negedge clock);
        checks++; if ({busIf.trans, busIf.address} !== {BUS_TRANSFER_NONSEQ, RESET_PC}) begin failures++; $display("[TB] FAIL seq_issue: got trans=%0d addr=%h want 2/%h", busIf.trans, busIf.address, RESET_PC); end
        @(negedge clock);
        checks++; if ({decIf.valid, decoderPc, decIf.data, fetchError} !== {1'b1, RESET_PC, memWord(RESET_PC), 1'b0}) begin failures++; $display("[TB] FAIL seq_first: got v=%b pc=%h d=%h e=%b want 1/%h", decIf.valid, decoderPc, decIf.data, fetchError, RESET_PC); end
        for (int k = 1; k < 3; k++) begin
            expPc = RESET_PC + 32'(4 * k);
            n = 0;
            do begin @(negedge clock); n++; end while (!decIf.valid && n < 10);
            checks++; if ({decIf.valid, decoderPc, decIf.data, fetchError} !== {1'b1, expPc, memWord(expPc), 1'b0}) begin failures++; $display("[TB] FAIL seq_word%0d: got v=%b pc=%h d=%h e=%b want 1/%h", k, decIf.valid, decoderPc, decIf.data, fetchError, expPc); end
        end
    endtask

    task automatic test_full();
        int completions;
        logic [31:0] expPc;
        decReady = 1'b0;
        applyRedirect(32'h200);
        completions = 0;
        for (int i = 0; i < 20; i++) begin
            if (busIf.trans != BUS_TRANSFER_IDLE && busIf.ready) completions++;
            @(negedge clock);
        end
        checks++; if (completions != 4) begin failures++; $display("[TB] FAIL full_transfers: got %0d want 4", completions); end
        checks++; if ({decIf.valid, busIf.trans} !== {1'b1, BUS_TRANSFER_IDLE}) begin failures++; $display("[TB] FAIL full_hold: got v=%b trans=%0d want 1/0", decIf.valid, busIf.trans); end
        decReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expPc = 32'h200 + 32'(4 * i);
            checks++; if ({decIf.valid, decoderPc, decIf.data} !== {1'b1, expPc, memWord(expPc)}) begin failures++; $display("[TB] FAIL full_drain%0d: got v=%b pc=%h d=%h want 1/%h", i, decIf.valid, decoderPc, decIf.data, expPc); end
            @(negedge clock);
        end
    endtask

    task automatic test_redirect_discard();
        int n;
        bit staleSeen;
        waitStates = 3;
        applyRedirect(32'h300);
        n = 0;
        while (!decIf.valid && n < 60) begin @(negedge clock); n++; end
        checks++; if ({decIf.valid, decoderPc} !== {1'b1, 32'h300}) begin failures++; $display("[TB] FAIL disc_setup: got v=%b pc=%h want 1/00000300", decIf.valid, decoderPc); end
        n = 0;
        do begin @(negedge clock); n++; end while (busIf.trans == BUS_TRANSFER_IDLE && n < 20);
        checks++; if ({busIf.trans != BUS_TRANSFER_IDLE, busIf.ready} !== 2'b10) begin failures++; $display("[TB] FAIL disc_pending: got trans=%0d ready=%b want busy/0", busIf.trans, busIf.ready); end
        applyRedirect(32'h2002);
        checks++; if ({decIf.valid, busIf.trans} !== {1'b0, BUS_TRANSFER_IDLE}) begin failures++; $display("[TB] FAIL disc_flush: got v=%b trans=%0d want 0/0", decIf.valid, busIf.trans); end
        staleSeen = 0;
        n = 0;
        while (busIf.trans == BUS_TRANSFER_IDLE && n < 30) begin
            if (decIf.valid) staleSeen = 1;
            @(negedge clock); n++;
        end
        checks++; if (staleSeen) begin failures++; $display("[TB] FAIL disc_dropped: got stale entry want none"); end
        checks++; if ({busIf.trans, busIf.address} !== {BUS_TRANSFER_NONSEQ, 32'h2000}) begin failures++; $display("[TB] FAIL disc_restart: got trans=%0d addr=%h want 2/00002000", busIf.trans, busIf.address); end
        n = 0;
        while (!decIf.valid && n < 30) begin @(negedge clock); n++; end
        checks++; if ({decIf.valid, decoderPc, decIf.data} !== {1'b1, 32'h2000, memWord(32'h2000)}) begin failures++; $display("[TB] FAIL disc_word: got v=%b pc=%h d=%h want 1/00002000", decIf.valid, decoderPc, decIf.data); end
    endtask

    task automatic test_error();
        int n, k, issued, valids;
        logic [31:0] expPc, expData;
        logic        expErr;
        waitStates = 0;
        errAddr    = 32'h10C;
        applyRedirect(32'h104);
        k = 0; n = 0;
        while (k < 3 && n < 40) begin
            if (decIf.valid) begin
                expPc   = 32'h104 + 32'(4 * k);
                expErr  = (k == 2);
                expData = expErr ? 32'h0 : memWord(expPc);
                checks++; if ({decoderPc, decIf.data, fetchError} !== {expPc, expData, expErr}) begin failures++; $display("[TB] FAIL err_entry%0d: got pc=%h d=%h e=%b want %h/%h/%b", k, decoderPc, decIf.data, fetchError, expPc, expData, expErr); end
                k++;
            end
            @(negedge clock); n++;
        end
        checks++; if (k != 3) begin failures++; $display("[TB] FAIL err_entries: got %0d want 3", k); end
        issued = 0; valids = 0;
        for (int i = 0; i < 10; i++) begin
            if (busIf.trans != BUS_TRANSFER_IDLE) issued++;
            if (decIf.valid) valids++;
            @(negedge clock);
        end
        checks++; if ({issued, valids} != {32'd0, 32'd0}) begin failures++; $display("[TB] FAIL err_halted: got issued=%0d valid=%0d want 0/0", issued, valids); end
        errAddr = 32'hFFFF_FFF0;
        applyRedirect(32'h0);
        n = 0;
        while (!decIf.valid && n < 10) begin @(negedge clock); n++; end
        checks++; if ({decIf.valid, decoderPc, fetchError} !== {1'b1, 32'h0, 1'b0}) begin failures++; $display("[TB] FAIL err_resume: got v=%b pc=%h e=%b want 1/0/0", decIf.valid, decoderPc, fetchError); end
    endtask

    task automatic test_same_cycle();
        int n;
        decReady = 1'b0;
        applyRedirect(32'h500);
        n = 0;
        while (!(busIf.trans != BUS_TRANSFER_IDLE && decIf.valid) && n < 20) begin @(negedge clock); n++; end
        checks++; if ({decIf.valid, decoderPc, busIf.ready} !== {1'b1, 32'h500, 1'b1}) begin failures++; $display("[TB] FAIL same_setup: got v=%b pc=%h ready=%b want 1/00000500/1", decIf.valid, decoderPc, busIf.ready); end
        decReady = 1'b1;
        applyRedirect(32'h604);
        checks++; if (decIf.valid !== 1'b0) begin failures++; $display("[TB] FAIL same_count: got v=%b want 0", decIf.valid); end
        n = 0;
        while (busIf.trans == BUS_TRANSFER_IDLE && n < 10) begin @(negedge clock); n++; end
        checks++; if (busIf.address !== 32'h604) begin failures++; $display("[TB] FAIL same_fp: got %h want 00000604", busIf.address); end
        n = 0;
        while (!decIf.valid && n < 10) begin @(negedge clock); n++; end
        checks++; if ({decIf.valid, decoderPc} !== {1'b1, 32'h604}) begin failures++; $display("[TB] FAIL same_next: got v=%b pc=%h want 1/00000604", decIf.valid, decoderPc); end
    endtask

    task automatic test_boundary();
        int n, k;
        bus_transfer_t transSeen [3];
        logic [31:0]   addrSeen  [3];
        bus_transfer_t expTrans  [3];
        expTrans[0] = BUS_TRANSFER_NONSEQ;
`ifdef FETCH_QUEUE_BURST_EN
        expTrans[1] = BUS_TRANSFER_SEQ;
`else
        expTrans[1] = BUS_TRANSFER_NONSEQ;
`endif
        expTrans[2] = BUS_TRANSFER_NONSEQ;
        applyRedirect(32'h3F8);
        k = 0; n = 0;
        while (k < 3 && n < 20) begin
            if (busIf.trans != BUS_TRANSFER_IDLE) begin
                transSeen[k] = busIf.trans;
                addrSeen[k]  = busIf.address;
                k++;
            end
            @(negedge clock); n++;
        end
        checks++; if (k != 3) begin failures++; $display("[TB] FAIL bnd_count: got %0d want 3", k); end
        for (int j = 0; j < k; j++) begin
            checks++; if ({transSeen[j], addrSeen[j]} !== {expTrans[j], 32'h3F8 + 32'(4 * j)}) begin failures++; $display("[TB] FAIL bnd_xfer%0d: got trans=%0d addr=%h want %0d/%h", j, transSeen[j], addrSeen[j], expTrans[j], 32'h3F8 + 32'(4 * j)); end
        end
    endtask

    task automatic test_reset_abort();
        int n;
        waitStates = 3;
        applyRedirect(32'h700);
        n = 0;
        while (busIf.trans == BUS_TRANSFER_IDLE && n < 20) begin @(negedge clock); n++; end
        reset = 1'b0;
        #1;
        checks++; if ({busIf.trans, busIf.address, decIf.valid, decoderPc} !== {BUS_TRANSFER_IDLE, 32'h0, 1'b0, 32'h0}) begin failures++; $display("[TB] FAIL abort_reset: got trans=%0d addr=%h v=%b pc=%h want 0/0/0/0", busIf.trans, busIf.address, decIf.valid, decoderPc); end
        @(negedge clock);
        waitStates = 0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++; if ({decIf.valid, decoderPc} !== {1'b1, RESET_PC}) begin failures++; $display("[TB] FAIL abort_restart: got v=%b pc=%h want 1/%h", decIf.valid, decoderPc, RESET_PC); end
    endtask

    initial begin
        reset        = 1'b0;
        redirect     = 1'b0;
        redirectPc   = 32'h0;
        decReady     = 1'b1;
        busAvailable = 1'b1;
        waitStates   = 0;
        errAddr      = 32'hFFFF_FFF0;
        test_reset();
        test_sequential();
        test_full();
        test_redirect_discard();
        test_error();
        test_same_cycle();
        test_boundary();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction prefetch unit that replaces the single-shot fetcher between the bus master port and the decoder. It keeps its own sequential fetch pointer, keeps the decoder fed from a DEPTH-entry prefetch FIFO, and accepts redirects from execute, flushing stale work. Bus errors are delivered in order to the decoder as tagged entries, and the unit halts until the next redirect.

## Interface
Parameters:
- DEPTH, 4: prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000: fetch pointer value after reset; word aligned.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- redirect  in  1  single-cycle pulse that flushes the unit and restarts fetch.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored and treated as 0.
- bus  bus_master.out  -  drives address, write, trans; samples available, ready, response, read_data.
- decoder  skid_buffer_port.downstream  -  drives valid and data; samples ready.
- decoder_pc  out  32  address of the FIFO head; qualified by decoder.valid.
- fetch_error  out  1  the FIFO head is a bus-error entry; qualified by decoder.valid.

## Operation
- Fetch pointer fp: 32 bits, starting at RESET_PC. It increments by 4 on each OKAY response and wraps modulo 2^32 with no special handling.
- FIFO: DEPTH entries of {pc[31:0], data[31:0], err}, with a count register of $clog2(DEPTH)+1 bits. decoder.valid = (count != 0). decoder.data, decoder_pc and fetch_error come combinationally from the head.
- Pop: when decoder.valid && decoder.ready. Push: on a completed transfer. Push and pop in the same cycle leave count unchanged.
- FSM states:
  - IDLE: issue when bus.available && bus.ready && count < DEPTH && !redirect. Set bus.address <= fp, bus.write <= 0, bus.trans <= NONSEQ, then go to WAITING. At most one transfer is outstanding, so a space is always reserved for its response.
  - WAITING: when bus.ready && response OKAY, push {fp, read_data, 0}, set fp += 4, drive trans IDLE and go to IDLE. When bus.ready && response ERROR, push {fp, 32'h0, 1}, drive trans IDLE and go to HALTED. When !bus.ready, hold all bus outputs.
  - DISCARD: entered on a redirect while a transfer is outstanding. Drive trans IDLE. On bus.ready, drop the response without pushing and go to IDLE.
  - HALTED: no issue. The error entry drains normally. Leave only on redirect.
- Redirect has priority over every other event in the same cycle:
  - count <= 0, so any same-cycle pop is lost and any same-cycle response is not pushed.
  - fp <= {redirect_pc[31:2], 2'b00}.
  - Next state is DISCARD if in WAITING and bus.ready is low that cycle; otherwise IDLE.
- Redirect in DISCARD restarts nothing extra: fp updates and the state stays DISCARD.
- Full FIFO: IDLE holds with trans IDLE until a pop frees a space. Empty FIFO: decoder.valid is 0 and the head fields are don't-care.

## Timing
- Reset values:
  - state IDLE, fp = RESET_PC, count 0.
  - bus.trans = BUS_TRANSFER_IDLE, bus.write 0, bus.address 0.
  - decoder.valid 0, decoder.data 0, decoder_pc 0, fetch_error 0.
- Reset asserted mid-transfer abandons the transfer immediately; the unit does not wait for bus.ready.
- Issue latency: address phase starts the cycle after the IDLE issue condition is sampled.
- Fill latency: a response sampled at edge N makes decoder.valid 1 in the cycle after edge N. Best case from empty is 3 cycles: issue, data, valid.
- Throughput: 1 word per 2 cycles with zero-wait-state slaves (NONSEQ mode).
- Redirect at edge N: decoder.valid is 0 after edge N, and the first fetch from redirect_pc issues at edge N+1 at the earliest.

## Configuration
- FETCH_QUEUE_BURST_EN defined:
  - In WAITING, an OKAY response with space remaining (count after push < DEPTH) and no redirect issues the next address immediately with trans SEQ. The FSM stays in WAITING, giving 1 word per cycle.
  - NONSEQ is used instead when the new address crosses a 1 KB boundary (new fp[9:0] == 0).
  - Otherwise it falls back to trans IDLE and returns to IDLE.
- Undefined: every transfer is NONSEQ followed by IDLE, exactly as described in Operation.

## Test plan
- Reset release with RESET_PC=32'h100, decoder.ready=1, zero-wait slave -> decoder sees pcs 100, 104, 108 in order with matching memory words. fetch_error stays 0.
- decoder.ready=0 for 20 cycles with DEPTH=4 -> exactly 4 transfers, count saturates at 4, bus.trans IDLE while full. Releasing ready drains 4 words in 4 cycles.
- Redirect to 32'h2002 while a transfer is outstanding with 3 wait states -> that response is dropped, FIFO is empty, and the next bus.address is 32'h2000.
- Slave returns ERROR at 32'h10C -> entry {10C, 0, err=1} reaches the decoder, no further transfers occur, and a redirect to 32'h0 resumes fetch.
- Redirect, response and pop in the same cycle -> count 0, no push, fp equals the redirect target.
- With FETCH_QUEUE_BURST_EN from fp=32'h3F8 -> trans sequence is NONSEQ, SEQ, then NONSEQ at 32'h400.
